dram_pipe: RTL
==============

# dram_pipe

Parametrised behavioural DRAM model for the `nn` DMA port: a word-addressed memory with byte-enabled writes, a fixed configurable read latency, and a credit-limited read-return queue with downstream backpressure. It sits in the testbench opposite `nn`, driving `i_dma_rd_data` and `i_dma_rd_ready`, so the accelerator's DMA engine can be exercised against realistic latency and stalls instead of a zero-latency constant source.

## Interface
- `DATA_W`, 16: word width in bits; must be a multiple of 8.
- `ADDR_W`, 10: address width; depth is 2^ADDR_W words.
- `RD_LAT`, 2: cycles from read acceptance to data entering the return queue; minimum 1.
- `QUEUE_DEPTH`, 4: maximum reads outstanding (in flight plus queued); minimum 1.
- `STUB_PATTERN`, 16'h0101: constant read data when `DRAM_PIPE_STUB_EN` is defined; `DATA_W` bits wide.

Ports:
- `i_clk`  in  1  single clock; all state updates on the rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_wr_en`  in  1  write strobe.
- `i_wr_addr`  in  ADDR_W  write word address.
- `i_wr_data`  in  DATA_W  write data.
- `i_wr_be`  in  DATA_W/8  byte enables; bit k covers bits [8k+7:8k].
- `i_rd_en`  in  1  read request.
- `i_rd_addr`  in  ADDR_W  read word address.
- `o_rd_ready`  out  1  request can be accepted (credit available).
- `o_rd_valid`  out  1  head of return queue is valid.
- `o_rd_data`  out  DATA_W  head-of-queue data.
- `i_rd_data_ready`  in  1  consumer pops the head this cycle.

## Operation
- Write: on an edge with `i_wr_en`=1, each byte lane with its `i_wr_be` bit set is updated; other lanes are unchanged. Writes are never stalled.
- Read accept: a request is accepted on an edge where `i_rd_en`=1 and `o_rd_ready`=1. Requests presented with `o_rd_ready`=0 are ignored, not queued. The requester must hold or re-issue them.
- Array data is sampled at the accept edge and carried through an RD_LAT-stage valid/data shift pipeline, then pushed into the return FIFO, which is QUEUE_DEPTH entries deep.
- Credit counter:
  - Resets to QUEUE_DEPTH.
  - Decrements on accept and increments on pop. A simultaneous accept and pop leaves it unchanged.
  - `o_rd_ready` = (credits != 0), decoded combinationally from the registered counter.
- Because of credits, a FIFO push can never overflow. No overflow logic is permitted beyond an assertion.
- Pop: an edge with `o_rd_valid`=1 and `i_rd_data_ready`=1 removes the head. `i_rd_data_ready` while empty has no effect.
- Return order is strictly the acceptance order.
- Same-edge write and read to the same address is read-before-write: the read returns the old data.
- FIFO pointers wrap modulo QUEUE_DEPTH. Full and empty are distinguished by an occupancy count.

## Timing
- Reset values: `o_rd_valid`=0, `o_rd_data`=0, `o_rd_ready`=1, credits=QUEUE_DEPTH, pipeline valids=0, FIFO empty. The memory array is not reset.
- Reset asserted mid-operation: all in-flight and queued reads are dropped immediately (asynchronously). Memory contents are retained.
- Latency: accept at edge t gives `o_rd_valid`=1 just after edge t+RD_LAT if the queue was empty. With a continuous `i_rd_data_ready`=1 and QUEUE_DEPTH ≥ RD_LAT+1, the read path sustains one word per cycle.
- `o_rd_data` is `o_rd_valid`-qualified. It is 0 whenever the FIFO is empty.
- Output stability: while `o_rd_valid`=1 and `i_rd_data_ready`=0, `o_rd_data` holds unchanged.

## Configuration
- `DRAM_PIPE_STUB_EN` defined:
  - Every returned read word is `STUB_PATTERN` regardless of address.
  - Writes still update the array.
  - Latency, credit and backpressure behaviour are identical to the normal mode.
- `DRAM_PIPE_STUB_EN` undefined: returned data comes from the array as described above.

## Test plan
- Write 16'h1234 to addr 5 with be=2'b11, then read addr 5 (RD_LAT=2) -> `o_rd_valid` rises 2 edges after acceptance, data 16'h1234.
- Partial write: addr 5 holds 16'h1234; write 16'hABCD with be=2'b01, then read addr 5 -> 16'h12CD.
- Backpressure: hold `i_rd_data_ready`=0 and present 5 back-to-back reads (QUEUE_DEPTH=4) to addrs 0..4 -> 4 accepted, `o_rd_ready`=0 from the 4th accept on, 5th ignored. Then raise `i_rd_data_ready` -> addrs 0..3 data returned in order, `o_rd_ready` back to 1 after the first pop.
- Same-edge write 16'h0002 and read at addr 7, which holds 16'h0001 -> read returns 16'h0001. A following read of addr 7 returns 16'h0002.
- Assert `i_rd` reset with 2 reads in flight -> `o_rd_valid`=0 immediately and no data after release. Credits=4, memory contents at addr 5 intact.
- Compile with `DRAM_PIPE_STUB_EN`, write 16'h00FF to addr 3, read addr 3 -> 16'h0101 after RD_LAT cycles.

Source files
------------

// File: rtl/dram_pipe.sv
// dram_pipe: behavioural DRAM with byte-enabled writes, fixed read latency and a credit-limited return queue.
// Define DRAM_PIPE_STUB_EN to return STUB_PATTERN for every read while keeping timing identical.
module dram_pipe #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2,
  parameter int QUEUE_DEPTH = 4,
  parameter logic [DATA_W-1:0] STUB_PATTERN = 16'h0101
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_wr_en,
  input  logic [ADDR_W-1:0]   i_wr_addr,
  input  logic [DATA_W-1:0]   i_wr_data,
  input  logic [DATA_W/8-1:0] i_wr_be,
  input  logic                i_rd_en,
  input  logic [ADDR_W-1:0]   i_rd_addr,
  output logic                o_rd_ready,
  output logic                o_rd_valid,
  output logic [DATA_W-1:0]   o_rd_data,
  input  logic                i_rd_data_ready
);
  localparam int PW = QUEUE_DEPTH > 1 ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] QD = CW'(QUEUE_DEPTH);
  localparam logic [PW-1:0] PLAST = PW'(QUEUE_DEPTH - 1);
`ifdef DRAM_PIPE_STUB_EN
  localparam bit STUB = 1'b1;
`else
  localparam bit STUB = 1'b0;
`endif
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] fifo_q [QUEUE_DEPTH];
  logic [DATA_W-1:0] pd_q [RD_LAT];
  logic [RD_LAT-1:0] pv_q, pv_d;
  logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]     cnt_q, cnt_d, cr_q, cr_d;
  logic              acc, pop, push;
  logic [DATA_W-1:0] rd_word;
  assign o_rd_ready = cr_q != '0;
  assign o_rd_valid = cnt_q != '0;
  assign o_rd_data  = o_rd_valid ? fifo_q[rp_q] : '0;
  always_comb begin
    acc     = i_rd_en && o_rd_ready;
    pop     = o_rd_valid && i_rd_data_ready;
    push    = pv_q[RD_LAT-1];
    rd_word = STUB ? STUB_PATTERN : mem_q[i_rd_addr];
    pv_d    = (pv_q << 1) | RD_LAT'(acc);
    wp_d    = push ? (wp_q == PLAST ? '0 : wp_q + 1'b1) : wp_q;
    rp_d    = pop ? (rp_q == PLAST ? '0 : rp_q + 1'b1) : rp_q;
    cnt_d   = push && !pop ? cnt_q + 1'b1 : (pop && !push ? cnt_q - 1'b1 : cnt_q);
    cr_d    = acc && !pop ? cr_q - 1'b1 : (pop && !acc ? cr_q + 1'b1 : cr_q);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pv_q  <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      cr_q  <= QD;
    end else begin
      pv_q  <= pv_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      cr_q  <= cr_d;
    end
  end
  // Data paths carry no reset: everything downstream is qualified by the valid bits.
  always_ff @(posedge i_clk) begin
    if (i_wr_en)
      for (int k = 0; k < DATA_W/8; k++)
        if (i_wr_be[k]) mem_q[i_wr_addr][8*k +: 8] <= i_wr_data[8*k +: 8];
    pd_q[0] <= rd_word;
    for (int i = 1; i < RD_LAT; i++) pd_q[i] <= pd_q[i-1];
    if (push) fifo_q[wp_q] <= pd_q[RD_LAT-1];
  end
  always_ff @(posedge i_clk) if (!i_rst) assert (!(push && !pop && cnt_q == QD));
endmodule
